delayfixed_seq_arb: RTL

- Sequences and shares one rise-edge fixed-delay cell (5 ns, 6 V domain) between NREQ digital requesters in the stepdown loop-control block.
- Grants the cell round-robin and launches a rising edge on the cell input.
- Detects the delayed edge on the cell output through a synchronizer, then releases the cell and reports completion or timeout to the granted requester.

---
 rtl/delayfixed_seq_arb.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/delayfixed_seq_arb.sv
// Round-robin sequencer sharing one rise-edge fixed-delay cell
// between NREQ requesters; reports done or timeout per sequence.
module delayfixed_seq_arb #(
  parameter int NREQ        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TMO_CYC     = 32,
  parameter int CNT_W       = 8
) (
  input  logic            CELCLK,
  input  logic            CELRSTN,
  input  logic            CELV,
  input  logic            CELG,
  input  logic            CELSUB,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            dly_i,
  input  logic            dly_o,
  output logic            done,
  output logic            tmo,
  output logic            busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {
    IDLE, LAUNCH, WAIT_HI, RELEASE, WAIT_LO, FINISH
  } state_t;

  state_t state, state_n;

  logic [CNT_W-1:0]       cnt, cnt_n, cnt_inc;
  logic [IW-1:0]          ptr, ptr_n;
  logic [IW-1:0]          gidx, gidx_n;
  logic [IW-1:0]          sel_idx, idx;
  logic [IW:0]            sum;
  logic                   sel_vld;
  logic [NREQ-1:0]        gnt_n;
  logic                   done_n, tmo_n;
  logic [SYNC_STAGES-1:0] sync;
  logic                   os;
  logic                   unused_supply;

  // Supply pins only pass through to the analog cell
  assign unused_supply = CELV ^ CELG ^ CELSUB;

  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) sync <= '0;
    else          sync <= {sync[SYNC_STAGES-2:0], dly_o};
  end

  assign os = sync[SYNC_STAGES-1];

  // Scan downward so the lowest offset from ptr wins
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    sum     = '0;
    idx     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NREQ))
        sum = sum - (IW+1)'(NREQ);
      idx = sum[IW-1:0];
      if (req[idx]) begin
        sel_vld = 1'b1;
        sel_idx = idx;
      end
    end
  end

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    gnt_n   = gnt;
    ptr_n   = ptr;
    gidx_n  = gidx;
    done_n  = 1'b0;
    tmo_n   = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (sel_vld) begin
          state_n = LAUNCH;
          gidx_n  = sel_idx;
          gnt_n   = {{(NREQ-1){1'b0}}, 1'b1} << sel_idx;
        end
      end
      LAUNCH: begin
        state_n = WAIT_HI;
        cnt_n   = '0;
      end
      WAIT_HI: begin
        cnt_n = cnt_inc;
        if (os) begin
          state_n = RELEASE;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = FINISH;
          tmo_n   = 1'b1;
        end
      end
      RELEASE: begin
        state_n = WAIT_LO;
        cnt_n   = '0;
      end
      WAIT_LO: begin
        cnt_n = cnt_inc;
        if (!os) begin
          state_n = FINISH;
          done_n  = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_n = FINISH;
          tmo_n   = 1'b1;
        end
      end
      FINISH: begin
        state_n = IDLE;
        gnt_n   = '0;
        ptr_n   = (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) begin
      state <= IDLE;
      cnt   <= '0;
      ptr   <= '0;
      gidx  <= '0;
      gnt   <= '0;
      dly_i <= 1'b0;
      done  <= 1'b0;
      tmo   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      ptr   <= ptr_n;
      gidx  <= gidx_n;
      gnt   <= gnt_n;
      dly_i <= (state_n == WAIT_HI);
      done  <= done_n;
      tmo   <= tmo_n;
      busy  <= (state_n != IDLE);
    end
  end

endmodule
